// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: PC source codes, reset
// vector, fetch FSM states and the fetch-group record layout.
package if_fetch_unit_pkg;

    localparam logic [2:0]  PCSRC_SEQ    = 3'b000;
    localparam logic [2:0]  PCSRC_BRANCH = 3'b001;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

    localparam int unsigned FETCH_WIDTH_MAX = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]                         pc;
        logic [FETCH_WIDTH_MAX-1:0][31:0]    inst;
    } fetch_group_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a one-outstanding req/ack
// handshake to instruction memory and registers one fetch group for IF/ID.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned FETCH_WIDTH  = 2,
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      Inst_Req_En,
    input  logic                      IF_Stall,
    input  logic [2:0]                PCsrcSel,
    input  logic [31:0]               Branch_Target,
    output logic                      Imem_Req,
    output logic [31:0]               Imem_Addr,
    input  logic                      Imem_Ack,
    input  logic [32*FETCH_WIDTH-1:0] Imem_Rdata,
    output logic                      Inst_Ready,
    output logic [31:0]               Fetch_PC,
    output logic [32*FETCH_WIDTH-1:0] Fetch_Inst
);

    localparam logic [31:0] PC_STEP = 32'(4 * FETCH_WIDTH);

    fetch_state_t state_q, state_d;

    logic [31:0]               pc_q;
    logic [31:0]               pend_q;
    logic                      issued_q;
    logic                      ready_q;
    logic [31:0]               fetch_pc_q;
    logic [32*FETCH_WIDTH-1:0] fetch_inst_q;

    logic        redirect;
    logic [31:0] target;
    logic        consume;
    logic        slot_free;
    logic        ack;
    logic        capture;

    assign redirect  = (PCsrcSel == PCSRC_BRANCH);
    assign target    = word_align(Branch_Target);
    assign consume   = ready_q & ~IF_Stall;
    assign slot_free = ~ready_q | consume;
    assign ack       = Imem_Ack & Imem_Req;

    assign Imem_Addr  = pc_q;
    assign Inst_Ready = ready_q;
    assign Fetch_PC   = fetch_pc_q;
    assign Fetch_Inst = fetch_inst_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Inst_Req_En && slot_free && !redirect) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (Imem_Req) begin
                    if (ack) begin
                        capture = ~redirect;
                        state_d = Inst_Req_En ? REQ : IDLE;
                    end else if (redirect) begin
                        state_d = DROP;
                    end
                end else begin
                    // Nothing presented to memory yet, so the request may still be abandoned.
                    state_d = Inst_Req_En ? REQ : IDLE;
                end
            end
            DROP: begin
                if (ack) begin
                    state_d = Inst_Req_En ? REQ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // In REQ the request is held back while an unconsumed group occupies the
    // output slot; once presented (issued_q) it stays up until acked.
    always_comb begin
        Imem_Req = 1'b0;
        unique case (state_q)
            IDLE:    Imem_Req = 1'b0;
            REQ:     Imem_Req = issued_q | slot_free;
            DROP:    Imem_Req = 1'b1;
            default: Imem_Req = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_VECTOR;
            pend_q       <= RESET_VECTOR;
            issued_q     <= 1'b0;
            ready_q      <= 1'b0;
            fetch_pc_q   <= '0;
            fetch_inst_q <= '0;
        end else begin
            issued_q <= Imem_Req & ~ack;

            if (state_q == DROP) begin
                if (ack) begin
                    pc_q <= redirect ? target : pend_q;
                end else if (redirect) begin
                    pend_q <= target;
                end
            end else if (redirect) begin
                if (state_q == REQ && Imem_Req && !ack) begin
                    pend_q <= target;
                end else begin
                    pc_q <= target;
                end
            end else if (capture) begin
                pc_q <= pc_q + PC_STEP;
            end

            if (redirect) begin
                ready_q <= 1'b0;
            end else if (capture) begin
                ready_q <= 1'b1;
            end else if (consume) begin
                ready_q <= 1'b0;
            end

            if (capture) begin
                fetch_pc_q   <= pc_q;
                fetch_inst_q <= Imem_Rdata;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios with hand-computed
// addresses plus a scoreboard that matches every delivered group.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    localparam int unsigned FW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            Inst_Req_En;
    logic            IF_Stall;
    logic [2:0]      PCsrcSel;
    logic [31:0]     Branch_Target;
    logic            Imem_Req;
    logic [31:0]     Imem_Addr;
    logic            Imem_Ack;
    logic [32*FW-1:0] Imem_Rdata;
    logic            Inst_Ready;
    logic [31:0]     Fetch_PC;
    logic [32*FW-1:0] Fetch_Inst;

    int tests = 0;
    int fails = 0;

    // Memory model controls
    int unsigned ack_lat   = 0;
    logic        ack_allow = 1'b1;
    int unsigned wait_cnt;
    logic        drop_flag;
    logic        prev_pending;
    logic [31:0] prev_addr;

    logic [31:0] exp_q[$];

    if_fetch_unit #(
        .FETCH_WIDTH (FW),
        .RESET_VECTOR(32'hBFC0_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .Inst_Req_En  (Inst_Req_En),
        .IF_Stall     (IF_Stall),
        .PCsrcSel     (PCsrcSel),
        .Branch_Target(Branch_Target),
        .Imem_Req     (Imem_Req),
        .Imem_Addr    (Imem_Addr),
        .Imem_Ack     (Imem_Ack),
        .Imem_Rdata   (Imem_Rdata),
        .Inst_Ready   (Inst_Ready),
        .Fetch_PC     (Fetch_PC),
        .Fetch_Inst   (Fetch_Inst)
    );

    always #5 clk = ~clk;

    function automatic logic [32*FW-1:0] mem_group(input logic [31:0] addr);
        logic [32*FW-1:0] g;
        for (int i = 0; i < int'(FW); i++) begin
            g[32*i +: 32] = (addr + 32'(4 * i)) ^ 32'h5A5A_0F0F;
        end
        return g;
    endfunction

    assign Imem_Ack   = Imem_Req && ack_allow && (wait_cnt >= ack_lat);
    assign Imem_Rdata = mem_group(Imem_Addr);

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory side: ack timing, protocol stability, and expected-group pushes.
    always @(posedge clk) begin
        if (rst) begin
            wait_cnt     <= 0;
            drop_flag    <= 1'b0;
            prev_pending <= 1'b0;
        end else begin
            if (prev_pending) begin
                check("req_held", {127'd0, Imem_Req}, 128'd1);
                check("addr_stable", {96'd0, Imem_Addr}, {96'd0, prev_addr});
            end
            prev_pending <= Imem_Req && !Imem_Ack;
            prev_addr    <= Imem_Addr;
            wait_cnt     <= (Imem_Req && !Imem_Ack) ? wait_cnt + 1 : 0;
            if (Imem_Req && Imem_Ack) begin
                if (PCsrcSel != PCSRC_BRANCH && !drop_flag) exp_q.push_back(Imem_Addr);
                drop_flag <= 1'b0;
            end else if (Imem_Req && PCsrcSel == PCSRC_BRANCH) begin
                drop_flag <= 1'b1;
            end
        end
    end

    // Consumer side: every consumed group must match the oldest accepted request.
    always @(negedge clk) begin
        if (!rst && Inst_Ready && !IF_Stall) begin
            if (exp_q.size() == 0) begin
                check("unexpected_group", {96'd0, Fetch_PC}, 128'hDEAD);
            end else begin
                logic [31:0] epc;
                epc = exp_q.pop_front();
                check("sb_pc", {96'd0, Fetch_PC}, {96'd0, epc});
                check("sb_inst", {{(128-32*FW){1'b0}}, Fetch_Inst},
                      {{(128-32*FW){1'b0}}, mem_group(epc)});
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int i;
        Inst_Req_En = 1'b0;
        IF_Stall    = 1'b0;
        PCsrcSel    = PCSRC_SEQ;
        ack_allow   = 1'b1;
        for (i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!Imem_Req && !Inst_Ready) break;
        end
        if (i == 40) check("drain_timeout", 128'd1, 128'd0);
        next();
    endtask

    // One-cycle redirect from IDLE to set a known PC.
    task automatic set_pc(input logic [31:0] a);
        PCsrcSel      = PCSRC_BRANCH;
        Branch_Target = a;
        next();
        PCsrcSel = PCSRC_SEQ;
        @(negedge clk);
        check("idle_redirect_addr", {96'd0, Imem_Addr}, {96'd0, a});
        check("idle_redirect_req", {127'd0, Imem_Req}, 128'd0);
    endtask

    // Redirect a pending request (no ack), optionally redirect again in DROP.
    task automatic drop_seq(input logic [31:0] base, input logic [31:0] t1,
                            input logic t2_en, input logic [31:0] t2,
                            input logic [31:0] exp_next);
        set_pc(base);
        next();
        ack_allow   = 1'b0;
        Inst_Req_En = 1'b1;
        next();
        PCsrcSel = PCSRC_BRANCH; Branch_Target = t1;
        @(negedge clk);
        check("drop_req_addr", {96'd0, Imem_Addr}, {96'd0, base});
        next();
        PCsrcSel = t2_en ? PCSRC_BRANCH : PCSRC_SEQ; Branch_Target = t2;
        @(negedge clk);
        check("drop_hold_addr", {96'd0, Imem_Addr}, {96'd0, base});
        check("drop_hold_req", {127'd0, Imem_Req}, 128'd1);
        next();
        PCsrcSel  = PCSRC_SEQ;
        ack_allow = 1'b1;
        @(negedge clk);
        check("drop_ack_addr", {96'd0, Imem_Addr}, {96'd0, base});
        check("drop_no_ready", {127'd0, Inst_Ready}, 128'd0);
        next();
        @(negedge clk);
        check("post_drop_addr", {96'd0, Imem_Addr}, {96'd0, exp_next});
        check("post_drop_ready", {127'd0, Inst_Ready}, 128'd0);
        next();
        @(negedge clk);
        check("post_drop_fetch_pc", {96'd0, Fetch_PC}, {96'd0, exp_next});
        drain();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; Inst_Req_En = 1'b0; IF_Stall = 1'b0;
        PCsrcSel = PCSRC_SEQ; Branch_Target = '0;
        repeat (3) next();
        @(negedge clk);
        check("rst_req", {127'd0, Imem_Req}, 128'd0);
        check("rst_addr", {96'd0, Imem_Addr}, 128'hBFC0_0000);
        check("rst_ready", {127'd0, Inst_Ready}, 128'd0);
        check("rst_fetch_pc", {96'd0, Fetch_PC}, 128'd0);
        check("rst_fetch_inst", {{(128-32*FW){1'b0}}, Fetch_Inst}, 128'd0);
        next();

        // Start-up fetch, then stall with a full slot
        rst = 1'b0; Inst_Req_En = 1'b1; ack_lat = 0;
        next();
        @(negedge clk);
        check("first_req", {127'd0, Imem_Req}, 128'd1);
        check("first_addr", {96'd0, Imem_Addr}, 128'hBFC0_0000);
        next();
        IF_Stall = 1'b1;
        @(negedge clk);
        check("first_ready", {127'd0, Inst_Ready}, 128'd1);
        check("first_fetch_pc", {96'd0, Fetch_PC}, 128'hBFC0_0000);
        check("second_addr", {96'd0, Imem_Addr}, 128'hBFC0_0008);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_no_req", {127'd0, Imem_Req}, 128'd0);
            check("stall_pc_held", {96'd0, Fetch_PC}, 128'hBFC0_0000);
            check("stall_inst_held", {{(128-32*FW){1'b0}}, Fetch_Inst},
                  {{(128-32*FW){1'b0}}, mem_group(32'hBFC0_0000)});
            next();
        end
        IF_Stall = 1'b0;
        @(negedge clk);
        check("release_req", {127'd0, Imem_Req}, 128'd1);
        check("release_addr", {96'd0, Imem_Addr}, 128'hBFC0_0008);
        drain();

        // Redirect to an unaligned target while the request is pending
        drop_seq(32'h0000_2000, 32'h0000_1003, 1'b0, 32'h0, 32'h0000_1000);
        // Second redirect inside DROP replaces the pending target
        drop_seq(32'h0000_7000, 32'h0000_1003, 1'b1, 32'h0000_800B, 32'h0000_8008);

        // Redirect in the same cycle as ack
        set_pc(32'h0000_3000);
        next();
        Inst_Req_En = 1'b1; ack_lat = 0;
        next();
        PCsrcSel = PCSRC_BRANCH; Branch_Target = 32'h0000_4000;
        @(negedge clk);
        check("ackredir_addr", {96'd0, Imem_Addr}, 128'h0000_3000);
        check("ackredir_ack", {127'd0, Imem_Ack}, 128'd1);
        next();
        PCsrcSel = PCSRC_SEQ;
        @(negedge clk);
        check("ackredir_next_addr", {96'd0, Imem_Addr}, 128'h0000_4000);
        check("ackredir_no_ready", {127'd0, Inst_Ready}, 128'd0);
        drain();

        // Inst_Req_En falls while the request is outstanding
        set_pc(32'h0000_5000);
        next();
        ack_allow = 1'b0; Inst_Req_En = 1'b1;
        next();
        Inst_Req_En = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("enfall_req_held", {127'd0, Imem_Req}, 128'd1);
            check("enfall_addr", {96'd0, Imem_Addr}, 128'h0000_5000);
            next();
        end
        ack_allow = 1'b1;
        next();
        @(negedge clk);
        check("enfall_idle", {127'd0, Imem_Req}, 128'd0);
        check("enfall_ready", {127'd0, Inst_Ready}, 128'd1);
        check("enfall_fetch_pc", {96'd0, Fetch_PC}, 128'h0000_5000);
        drain();

        // 32-bit PC wrap-around
        set_pc(32'hFFFF_FFF8);
        next();
        Inst_Req_En = 1'b1; ack_lat = 0;
        next();
        next();
        Inst_Req_En = 1'b0;
        @(negedge clk);
        check("wrap_addr", {96'd0, Imem_Addr}, 128'h0000_0000);
        check("wrap_fetch_pc", {96'd0, Fetch_PC}, 128'hFFFF_FFF8);
        drain();

        // Slower memory with a stall pattern; scoreboard checks every group
        set_pc(32'h0000_9000);
        next();
        Inst_Req_En = 1'b1; ack_lat = 2;
        for (int k = 0; k < 30; k++) begin
            IF_Stall = (k % 7 == 3) || (k % 7 == 4) || (k % 11 == 8);
            next();
        end
        drain();
        ack_lat = 0;

        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
